// File: rtl/smaesh_stream_pkg.sv
// Shared definitions for the byte-serial masked-state streamer.
package smaesh_stream_pkg;

  localparam int N_BYTES = 16;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2,
    DRAIN   = 2'd3
  } stream_state_t;

endpackage

// File: rtl/shared_state_streamer_slice_mux.sv
// 16:1 selector picking one shared byte slice out of the full state.
module slice_mux
  import smaesh_stream_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic [N_BYTES*SLICE_W-1:0] data,
  input  logic [CNT_W-1:0]           sel,
  output logic [SLICE_W-1:0]         slice_sel
);

  // Plain indexed read; shares are moved untouched.
  always_comb begin
    slice_sel = data[int'(sel)*SLICE_W +: SLICE_W];
  end

endmodule

// File: rtl/shared_state_streamer.sv
// Loads a shared AES state byte by byte and presents it to the masked core,
// or captures a shared state from the core and streams it back out.
module shared_state_streamer
  import smaesh_stream_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [8*d-1:0]         in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_BYTES*8*d-1:0] st_out,
  output logic                   st_out_valid,
  input  logic                   st_out_ready,
  input  logic [N_BYTES*8*d-1:0] st_in,
  input  logic                   st_in_valid,
  output logic                   st_in_ready,
  output logic [8*d-1:0]         out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int SLICE_W = 8*d;
  localparam int STATE_W = N_BYTES*SLICE_W;

  stream_state_t        state;
  stream_state_t        next_state;
  logic [CNT_W-1:0]     cnt;
  logic [STATE_W-1:0]   buffer;
  logic [N_BYTES-1:0]   slice_we;
  logic [SLICE_W-1:0]   drain_slice;
  logic                 capture;
  logic                 load_beat;
  logic                 drain_beat;

  // Completed handshakes this cycle; flush suppresses all of them.
  always_comb begin
    capture    = !flush && (state == IDLE) && st_in_valid;
    load_beat  = !flush && in_valid &&
                 (((state == IDLE) && !st_in_valid) || (state == LOAD));
    drain_beat = !flush && (state == DRAIN) && out_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (capture)        next_state = DRAIN;
          else if (load_beat) next_state = LOAD;
        end
        LOAD:    if (load_beat && (cnt == LAST_CNT))  next_state = PRESENT;
        PRESENT: if (st_out_ready)                    next_state = IDLE;
        DRAIN:   if (drain_beat && (cnt == LAST_CNT)) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Byte counter; wraps to 0 naturally after byte 15 in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (flush || capture)       cnt <= '0;
    else if (load_beat || drain_beat) cnt <= cnt + 1'b1;
  end

  // Decoded write enable for the slice addressed by the counter.
  always_comb begin
    slice_we = '0;
    if (load_beat) slice_we[cnt] = 1'b1;
  end

  // Shared buffer: full capture from the core, or one slice per load beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
    end else if (capture) begin
      buffer <= st_in;
    end else begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (slice_we[i]) buffer[i*SLICE_W +: SLICE_W] <= in_data;
      end
    end
  end

  slice_mux #(
    .SLICE_W (SLICE_W)
  ) u_slice_mux (
    .data      (buffer),
    .sel       (cnt),
    .slice_sel (drain_slice)
  );

  // Outputs decoded from state/registers; in_ready in IDLE yields to st_in_valid.
  always_comb begin
    in_ready     = 1'b0;
    st_in_ready  = 1'b0;
    st_out_valid = 1'b0;
    st_out       = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    case (state)
      IDLE: begin
        st_in_ready = 1'b1;
        in_ready    = !st_in_valid;
      end
      LOAD: in_ready = 1'b1;
      PRESENT: begin
        st_out_valid = 1'b1;
        st_out       = buffer;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = drain_slice;
        out_last  = (cnt == LAST_CNT);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_state_streamer.sv
// Directed bench for shared_state_streamer (d=2 main instance, d=3 round trip).
module tb_shared_state_streamer;

  localparam int W = 384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         flush = 1'b0, in_valid = 1'b0, st_out_ready = 1'b0;
  logic         st_in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0]  in_data = '0;
  logic [255:0] st_in = '0;
  logic         in_ready, st_out_valid, st_in_ready, out_valid, out_last, busy;
  logic [15:0]  out_data;
  logic [255:0] st_out;

  logic         flush3 = 1'b0, in_valid3 = 1'b0, st_out_ready3 = 1'b0;
  logic         st_in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic [23:0]  in_data3 = '0;
  logic [383:0] st_in3 = '0;
  logic         in_ready3, st_out_valid3, st_in_ready3, out_valid3, out_last3, busy3;
  logic [23:0]  out_data3;
  logic [383:0] st_out3;

  int errors = 0;
  int checks = 0;

  logic [15:0]  exp_out_q[$];
  logic [255:0] exp_state_q[$];

  shared_state_streamer #(.d(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .st_out(st_out), .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
    .st_in(st_in), .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  shared_state_streamer #(.d(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .st_out(st_out3), .st_out_valid(st_out_valid3), .st_out_ready(st_out_ready3),
    .st_in(st_in3), .st_in_valid(st_in_valid3), .st_in_ready(st_in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_last(out_last3), .busy(busy3)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] interleave2(input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] r;
    for (int j = 0; j < 8; j++) begin
      r[2*j]   = s0[j];
      r[2*j+1] = s1[j];
    end
    return r;
  endfunction

  function automatic logic [7:0] recombine2(input logic [15:0] sl);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = sl[2*j] ^ sl[2*j+1];
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check_output({tag, " in_ready"},     W'(in_ready),     W'(1'b1));
    check_output({tag, " st_in_ready"},  W'(st_in_ready),  W'(1'b1));
    check_output({tag, " st_out"},       W'(st_out),       '0);
    check_output({tag, " st_out_valid"}, W'(st_out_valid), '0);
    check_output({tag, " out_data"},     W'(out_data),     '0);
    check_output({tag, " out_valid"},    W'(out_valid),    '0);
    check_output({tag, " out_last"},     W'(out_last),     '0);
    check_output({tag, " busy"},         W'(busy),         '0);
  endtask

  // Scoreboard compare: every meaningful output cycle is checked against the
  // queued expectations; a beat leaves the queue only when it is accepted.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_out_q.size() == 0) begin
        check_output("unexpected out_valid", W'(out_valid), '0);
      end else begin
        check_output("out_data", W'(out_data), W'(exp_out_q[0]));
        check_output("out_last", W'(out_last), W'(exp_out_q.size() == 1));
        if (out_ready) void'(exp_out_q.pop_front());
      end
    end
    if (st_out_valid) begin
      if (exp_state_q.size() == 0) begin
        check_output("unexpected st_out_valid", W'(st_out_valid), '0);
      end else begin
        check_output("st_out", W'(st_out), W'(exp_state_q[0]));
        if (st_out_ready) void'(exp_state_q.pop_front());
      end
    end
  end

  // Streams 16 slices in at full rate, then holds PRESENT for 'stall' cycles.
  task automatic apply_stimulus_load(input logic [255:0] vec, input int stall);
    exp_state_q.push_back(vec);
    st_out_ready = (stall == 0);
    for (int k = 0; k < 16; k++) begin
      in_data  = vec[16*k +: 16];
      in_valid = 1'b1;
      #1;
      check_output("load in_ready", W'(in_ready), W'(1'b1));
      if (k == 15) check_output("present not early", W'(st_out_valid), '0);
      step();
    end
    in_valid = 1'b0;
    check_output("present after 16th beat", W'(st_out_valid), W'(1'b1));
    check_output("busy in present", W'(busy), W'(1'b1));
    repeat (stall) step();
    st_out_ready = 1'b1;
    step();
    st_out_ready = 1'b0;
    check_output("idle after present", W'(busy), '0);
  endtask

  // Captures a state from the core side; optionally collides with in_valid.
  task automatic apply_stimulus_capture(input logic [255:0] vec, input logic collide);
    for (int k = 0; k < 16; k++) exp_out_q.push_back(vec[16*k +: 16]);
    st_in       = vec;
    st_in_valid = 1'b1;
    in_valid    = collide;
    in_data     = 16'hDEAD;
    #1;
    check_output("capture st_in_ready", W'(st_in_ready), W'(1'b1));
    check_output("capture in_ready", W'(in_ready), '0);
    step();
    st_in_valid = 1'b0;
    in_valid    = 1'b0;
    check_output("drain starts next cycle", W'(out_valid), W'(1'b1));
    check_output("drain st_in_ready", W'(st_in_ready), '0);
    check_output("drain in_ready", W'(in_ready), '0);
  endtask

  initial begin
    logic [255:0] vec_a, vec_b, vec_u;
    logic [383:0] vec3;
    int n;

    for (int i = 0; i < 16; i++) begin
      vec_a[16*i +: 16] = interleave2(8'(i), 8'hA5);
      vec_b[16*i +: 16] = interleave2(8'(i) ^ 8'h3C, 8'h5A);
      vec_u[16*i +: 16] = {8'(8'h11 * i), 8'(8'hC3 ^ i)};
    end
    for (int i = 0; i < 16; i++) vec3[24*i +: 24] = 24'(i * 24'h010203) ^ 24'h5A0F33;

    // Reset state.
    #3;
    check_reset_values("reset");
    step();
    rst_n = 1'b1;
    step();

    // Load with share0 = byte index, share1 = 0xA5.
    apply_stimulus_load(vec_a, 0);
    check_output("slice0 literal", W'(vec_a[15:0]), W'(16'h8822));
    check_output("slice15 literal", W'(vec_a[255:240]), W'(16'h8877));

    // Slice recombination at PRESENT, sampled on a stalled second load.
    exp_state_q.push_back(vec_a);
    for (int k = 0; k < 16; k++) begin
      in_data = vec_a[16*k +: 16];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++)
      check_output("recombine", W'(recombine2(st_out[16*k +: 16])), W'(8'(k) ^ 8'hA5));
    st_out_ready = 1'b1;
    step();
    st_out_ready = 1'b0;
    step();

    // Unload with out_ready toggling 1/0.
    apply_stimulus_capture(vec_u, 1'b0);
    n = 0;
    while (exp_out_q.size() != 0 && n < 100) begin
      out_ready = (n % 2 == 0);
      step();
      n++;
    end
    out_ready = 1'b0;
    check_output("drain bounded", W'(n < 100), W'(1'b1));
    check_output("idle after last beat", W'(busy), '0);
    exp_out_q.delete();
    step();

    // Simultaneous st_in_valid and in_valid: capture wins, beat not taken.
    apply_stimulus_capture(vec_b, 1'b1);
    out_ready = 1'b1;
    n = 0;
    while (exp_out_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check_output("collide drain bounded", W'(n < 100), W'(1'b1));
    check_output("collide idle after", W'(busy), '0);
    exp_out_q.delete();
    step();

    // Flush after 7 load beats, then a full stalled load.
    for (int k = 0; k < 7; k++) begin
      in_data = 16'hFFFF;
      in_valid = 1'b1;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_output("flush busy", W'(busy), '0);
    check_output("flush in_ready", W'(in_ready), W'(1'b1));
    check_output("flush st_out_valid", W'(st_out_valid), '0);
    apply_stimulus_load(vec_b, 3);
    step();

    // Reset asserted while byte 9 is on the output.
    apply_stimulus_capture(vec_u, 1'b0);
    out_ready = 1'b1;
    repeat (9) step();
    out_ready = 1'b0;
    check_output("byte 9 presented", W'(out_data), W'(vec_u[16*9 +: 16]));
    #2;
    rst_n = 1'b0;
    exp_out_q.delete();
    #1;
    check_reset_values("async reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_output("post-reset st_out", W'(st_out), '0);
    check_output("post-reset out_data", W'(out_data), '0);
    check_output("post-reset busy", W'(busy), '0);

    // d=3 round trip: load, present, capture same state, drain.
    st_out_ready3 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data3 = vec3[24*k +: 24];
      in_valid3 = 1'b1;
      step();
    end
    in_valid3 = 1'b0;
    check_output("d3 st_out_valid", W'(st_out_valid3), W'(1'b1));
    check_output("d3 st_out", st_out3, vec3);
    step();
    st_out_ready3 = 1'b0;
    check_output("d3 idle after present", W'(busy3), '0);
    st_in3 = vec3;
    st_in_valid3 = 1'b1;
    step();
    st_in_valid3 = 1'b0;
    out_ready3 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_output("d3 out_valid", W'(out_valid3), W'(1'b1));
      check_output("d3 out_data", W'(out_data3), W'(vec3[24*k +: 24]));
      check_output("d3 out_last", W'(out_last3), W'(k == 15));
      step();
    end
    out_ready3 = 1'b0;
    check_output("d3 idle after drain", W'(busy3), '0);

    check_output("scoreboard out empty", W'(exp_out_q.size()), '0);
    check_output("scoreboard state empty", W'(exp_state_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
